// File: rtl/led_pwm_if.sv
// Level handshake between the brightness generator (master) and led_pwm_driver (slave).
`timescale 1ns/1ps
interface led_pwm_if;
  logic [5:0] level;
  logic       level_valid;
  logic       level_ready;

  modport master (output level, output level_valid, input level_ready);
  modport slave  (input level, input level_valid, output level_ready);
endinterface

// File: rtl/led_pwm_driver.sv
// Six-channel phase-staggered PWM driver for active-low LEDs, double-buffered level updates.
// Optional build macro: LED_PWM_GAMMA_EN selects quadratic (gamma) level mapping.
`timescale 1ns/1ps
module led_pwm_driver #(
  parameter int unsigned PRESCALE_DIV = 1071,
  parameter int unsigned PHASE_STEP   = 10
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  led_pwm_if.slave        lvl_if,
  output logic [5:0]      led,
  output logic            period_start
);

  localparam int unsigned PRE_W  = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned SUM_W  = 9;
  localparam int unsigned NUM_CH = 6;
  localparam int unsigned PERIOD = 63;

  // Channel offsets are reduced at elaboration so one conditional subtract suffices at run time.
  function automatic logic [CNT_W-1:0] ch_offset(input int unsigned ch);
    return CNT_W'((ch * PHASE_STEP) % PERIOD);
  endfunction

  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [CNT_W-1:0]  shadow_q, shadow_d;
  logic [CNT_W-1:0]  active_q, active_d;
  logic              pending_q, pending_d;
  logic [NUM_CH-1:0] led_q, led_d;
  logic              period_start_q, period_start_d;

  logic              tick_c;
  logic              boundary_c;
  logic              accept_c;
  logic [CNT_W-1:0]  mapped_c;

`ifdef LED_PWM_GAMMA_EN
  logic [11:0]       gamma_prod_c;
  assign gamma_prod_c = 12'(lvl_if.level) * (12'(lvl_if.level) + 12'd1);
  assign mapped_c     = gamma_prod_c[11:6];
`else
  assign mapped_c     = lvl_if.level;
`endif

  assign lvl_if.level_ready = ~pending_q;
  assign tick_c     = (pre_cnt_q == PRE_W'(PRESCALE_DIV - 1));
  assign boundary_c = tick_c && (pwm_cnt_q == CNT_W'(PERIOD - 1));
  assign accept_c   = lvl_if.level_valid && ~pending_q;

  // Counters, double buffer and period marker.
  always_comb begin
    pre_cnt_d      = pre_cnt_q + PRE_W'(1);
    pwm_cnt_d      = pwm_cnt_q;
    shadow_d       = shadow_q;
    active_d       = active_q;
    pending_d      = pending_q;
    period_start_d = boundary_c;

    if (tick_c) begin
      pre_cnt_d = '0;
      pwm_cnt_d = (pwm_cnt_q == CNT_W'(PERIOD - 1)) ? '0 : pwm_cnt_q + CNT_W'(1);
    end
    if (boundary_c && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    // Accept only happens with pending low, so it never collides with a buffered transfer.
    if (accept_c) begin
      shadow_d  = mapped_c;
      pending_d = 1'b1;
    end
  end

  // Outputs use next-state values so the new level shows on led alongside period_start.
  always_comb begin
    logic [SUM_W-1:0] ph_sum;
    led_d  = '1;
    ph_sum = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ph_sum = SUM_W'(pwm_cnt_d) + SUM_W'(ch_offset(i));
      if (ph_sum >= SUM_W'(PERIOD)) begin
        ph_sum = ph_sum - SUM_W'(PERIOD);
      end
      led_d[i] = ~(ph_sum < SUM_W'(active_d));
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      pending_q      <= 1'b0;
      led_q          <= '1;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      led_q          <= led_d;
      period_start_q <= period_start_d;
    end
  end

  assign led          = led_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed self-checking bench for led_pwm_driver (PRESCALE_DIV = 2, period = 126 cycles).
`timescale 1ns/1ps
module tb_led_pwm_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] led0, led1;
  logic       ps0, ps1;
  int         n_cmp = 0;
  int         n_bad = 0;

  led_pwm_if if0();
  led_pwm_if if1();

  led_pwm_driver #(.PRESCALE_DIV(2), .PHASE_STEP(0)) dut0 (
    .sys_clk(clk), .sys_rst(rst), .lvl_if(if0), .led(led0), .period_start(ps0));
  led_pwm_driver #(.PRESCALE_DIV(2), .PHASE_STEP(10)) dut1 (
    .sys_clk(clk), .sys_rst(rst), .lvl_if(if1), .led(led1), .period_start(ps1));

  always #5 clk = ~clk;

  // Hand-computed level mapping for the levels this bench uses.
  function automatic int exp_f(input int x);
`ifdef LED_PWM_GAMMA_EN
    case (x)
      0: return 0;   1: return 0;   10: return 1;  16: return 4;
      32: return 16; 40: return 25; 63: return 63;
      default: return -1;
    endcase
`else
    return x;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if0.level = 6'd63; if0.level_valid = 1'b1;
    if1.level = 6'd63; if1.level_valid = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    if0.level_valid = 1'b0;
    if1.level_valid = 1'b0;
  endtask

  task automatic offer0(input logic [5:0] x);
    if0.level = x; if0.level_valid = 1'b1;
    step();
    if0.level_valid = 1'b0;
  endtask

  task automatic offer1(input logic [5:0] x);
    if1.level = x; if1.level_valid = 1'b1;
    step();
    if1.level_valid = 1'b0;
  endtask

  task automatic wait_ps0(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ps0) begin ok = 1'b1; return; end
      step();
    end
  endtask

  task automatic wait_ps1(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ps1) begin ok = 1'b1; return; end
      step();
    end
  endtask

  task automatic test_reset();
    int bad_ps, bad_led;
    do_reset();
    n_cmp++; if (led0 !== 6'h3f) begin n_bad++; $display("FAIL reset_led: got %b want 111111", led0); end
    n_cmp++; if (if0.level_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", if0.level_ready); end
    n_cmp++; if (ps0 !== 1'b0) begin n_bad++; $display("FAIL reset_ps: got %b want 0", ps0); end
    for (int p = 0; p < 2; p++) begin
      bad_ps = 0; bad_led = 0;
      for (int k = 1; k < 126; k++) begin
        step();
        if (ps0 !== 1'b0) bad_ps++;
        if (led0 !== 6'h3f) bad_led++;
      end
      n_cmp++; if (bad_ps != 0) begin n_bad++; $display("FAIL reset_quiet_p%0d: got %0d stray pulses want 0", p, bad_ps); end
      n_cmp++; if (bad_led != 0) begin n_bad++; $display("FAIL reset_led_p%0d: got %0d lit cycles want 0", p, bad_led); end
      step();
      n_cmp++; if (ps0 !== 1'b1) begin n_bad++; $display("FAIL reset_pulse_p%0d: got %b want 1", p, ps0); end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bit ok;
    do_reset();
    offer0(6'd63);
    repeat (20) step();
    do_reset();
    bad = 0;
    for (int k = 0; k < 126; k++) begin
      if (led0 !== 6'h3f || ps0 !== 1'b0) bad++;
      step();
    end
    wait_ps0(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_reset_ps: got timeout want pulse"); end
    for (int k = 0; k < 126; k++) begin
      if (led0 !== 6'h3f) bad++;
      step();
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL mid_reset_discard: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_double_buffer();
    int bad_pre, bad;
    bit ok;
    logic [5:0] want;
    do_reset();
    repeat (40) step();
    offer0(6'd16);
    bad_pre = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ps0) begin ok = 1'b1; break; end
      if (led0 !== 6'h3f) bad_pre++;
      step();
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL dbuf_ps: got timeout want pulse"); end
    n_cmp++; if (bad_pre != 0) begin n_bad++; $display("FAIL dbuf_early: got %0d early cycles want 0", bad_pre); end
    bad = 0;
    for (int k = 0; k < 252; k++) begin
      want = ((k % 126) < 2 * exp_f(16)) ? 6'h00 : 6'h3f;
      if (led0 !== want) bad++;
      if (ps0 !== ((k % 126) == 0)) bad++;
      step();
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL dbuf_duty: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int cyc, low;
    do_reset();
    if0.level = 6'd10; if0.level_valid = 1'b1;
    step();
    if0.level = 6'd40;
    n_cmp++; if (if0.level_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready: got %b want 0", if0.level_ready); end
    cyc = 1;
    while (if0.level_ready !== 1'b1 && cyc < 300) begin step(); cyc++; end
    n_cmp++; if (cyc != 126) begin n_bad++; $display("FAIL bp_hold: got ready at cycle %0d want 126", cyc); end
    n_cmp++; if (ps0 !== 1'b1) begin n_bad++; $display("FAIL bp_ready_ps: got %b want 1", ps0); end
    low = (led0 === 6'h00) ? 1 : 0;
    step();
    if0.level_valid = 1'b0;
    n_cmp++; if (if0.level_ready !== 1'b0) begin n_bad++; $display("FAIL bp_pending2: got %b want 0", if0.level_ready); end
    for (int k = 1; k < 126; k++) begin
      if (led0 === 6'h00) low++;
      step();
    end
    n_cmp++; if (low != 2 * exp_f(10)) begin n_bad++; $display("FAIL bp_first: got %0d lit cycles want %0d", low, 2 * exp_f(10)); end
    n_cmp++; if (ps0 !== 1'b1) begin n_bad++; $display("FAIL bp_second_ps: got %b want 1", ps0); end
    low = 0;
    for (int k = 0; k < 126; k++) begin
      if (led0 === 6'h00) low++;
      step();
    end
    n_cmp++; if (low != 2 * exp_f(40)) begin n_bad++; $display("FAIL bp_second: got %0d lit cycles want %0d", low, 2 * exp_f(40)); end
  endtask

  task automatic test_extremes();
    int bad;
    bit ok;
    do_reset();
    offer0(6'd63);
    wait_ps0(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ext_ps63: got timeout want pulse"); end
    bad = 0;
    for (int k = 0; k < 252; k++) begin
      if (led0 !== 6'h00) bad++;
      step();
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL ext_full_on: got %0d dark cycles want 0", bad); end
    offer0(6'd0);
    wait_ps0(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ext_ps0: got timeout want pulse"); end
    bad = 0;
    for (int k = 0; k < 252; k++) begin
      if (led0 !== 6'h3f) bad++;
      step();
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL ext_full_off: got %0d lit cycles want 0", bad); end
  endtask

  task automatic test_phase();
    int bad0, bad1, bad5, cnt, g;
    bit ok;
    do_reset();
    offer1(6'd10);
    wait_ps1(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL phase_ps: got timeout want pulse"); end
    g = exp_f(10);
    bad0 = 0; bad1 = 0; bad5 = 0;
    for (int k = 0; k < 126; k++) begin
      cnt = k / 2;
      if (led1[0] !== !(cnt < g)) bad0++;
      if (led1[1] !== !(cnt >= 53 && cnt < 53 + g)) bad1++;
      if (led1[5] !== !(cnt >= 13 && cnt < 13 + g)) bad5++;
      step();
    end
    n_cmp++; if (bad0 != 0) begin n_bad++; $display("FAIL phase_ch0: got %0d bad cycles want 0", bad0); end
    n_cmp++; if (bad1 != 0) begin n_bad++; $display("FAIL phase_ch1: got %0d bad cycles want 0", bad1); end
    n_cmp++; if (bad5 != 0) begin n_bad++; $display("FAIL phase_ch5: got %0d bad cycles want 0", bad5); end
  endtask

  task automatic test_gamma();
    int low;
    bit ok;
    do_reset();
    offer0(6'd32);
    wait_ps0(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL gamma_ps: got timeout want pulse"); end
    low = 0;
    for (int k = 0; k < 126; k++) begin
      if (led0[0] === 1'b0) low++;
      step();
    end
    n_cmp++; if (low != 2 * exp_f(32)) begin n_bad++; $display("FAIL gamma_32: got %0d lit cycles want %0d", low, 2 * exp_f(32)); end
    offer0(6'd1);
    wait_ps0(ok);
    low = 0;
    for (int k = 0; k < 126; k++) begin
      if (led0 !== 6'h3f) low++;
      step();
    end
    n_cmp++; if (low != 2 * exp_f(1)) begin n_bad++; $display("FAIL gamma_1: got %0d lit cycles want %0d", low, 2 * exp_f(1)); end
  endtask

  initial begin
    rst = 1'b1;
    if0.level = '0; if0.level_valid = 1'b0;
    if1.level = '0; if1.level_valid = 1'b0;
    test_reset();
    test_reset_mid();
    test_double_buffer();
    test_back_to_back();
    test_extremes();
    test_phase();
    test_gamma();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
